mc6502_seq_shifter: RTL and testbench
=====================================

MC6502_SEQ_SHIFTER -- requirements
Module: mc6502_seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data path width in bits (legal 2..32).
REQ-002 SHALL have parameter CW, default 4, shift-count width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  request a shift operation; sampled only when the block is not busy.
REQ-006 SHALL have port i_data  input  WIDTH  operand, captured with i_start.
REQ-007 SHALL have port i_count  input  CW  number of single-bit steps, captured with i_start.
REQ-008 SHALL have port i_rotate  input  1  1 = rotate through carry, 0 = shift.
REQ-009 SHALL have port i_right  input  1  1 = right, 0 = left.
REQ-010 SHALL have port i_arith  input  1  1 = arithmetic right shift; honoured only when i_right=1 and i_rotate=0, ignored otherwise.
REQ-011 SHALL have port i_c  input  1  carry-in, captured with i_start.
REQ-012 SHALL have port o_data  output  WIDTH  result register.
REQ-013 SHALL have ports o_n, o_z, o_c  output  1 each  negative, zero and carry flags of o_data.
REQ-014 SHALL have port o_busy  output  1  high while steps remain.
REQ-015 SHALL have port o_done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE; the reset state is IDLE.
REQ-017 In IDLE or DONE, i_start=1 at an edge SHALL load data, carry, mode and count; the next state SHALL be DONE if i_count=0, otherwise SHIFT with remaining=i_count.
REQ-018 In IDLE or DONE with i_start=0, the next state SHALL be IDLE.
REQ-019 In SHIFT, each edge SHALL perform exactly one step and decrement remaining; the next state SHALL be DONE when remaining was 1.
REQ-020 In SHIFT, i_start and all other operand inputs SHALL be ignored; a captured mode SHALL NOT change mid-operation.
REQ-021 Step ASL: c<=data[W-1]; data<={data[W-2:0],0}.
REQ-022 Step ROL: c<=data[W-1]; data<={data[W-2:0],c}.
REQ-023 Step LSR: c<=data[0]; data<={0,data[W-1:1]}.
REQ-024 Step ASR (i_arith): c<=data[0]; data<={data[W-1],data[W-1:1]}.
REQ-025 Step ROR: c<=data[0]; data<={c,data[W-1:1]}.
REQ-026 Rotates SHALL behave as a WIDTH+1-bit rotation through carry, so WIDTH+1 steps restore the original data and carry; counts larger than WIDTH SHALL be executed literally, with no modulo reduction.
REQ-027 o_busy SHALL be 1 only in SHIFT.
REQ-028 o_done SHALL be 1 only in DONE: one cycle after edge E_N of the operation (N=i_count ≥ 1), or one cycle after the load edge E_0 when N=0.
REQ-029 Back-to-back operation SHALL be supported: i_start in the DONE cycle SHALL begin a new operation with no idle gap.
REQ-030 o_n SHALL equal o_data[WIDTH-1], o_z SHALL equal (o_data==0), and o_c SHALL be the carry register, all updated every step.
REQ-031 o_data and flags SHALL hold their last value after DONE until the next load.
REQ-032 A count of 0 SHALL return o_data=i_data and o_c=i_c, with flags from i_data.

Reset
REQ-033 Asserting rst, at any time including mid-SHIFT, SHALL immediately force state IDLE, o_data=0, o_c=0, o_n=0, o_z=1, o_busy=0, o_done=0 and remaining=0.
REQ-034 While rst is high, i_start SHALL have no effect; the first load SHALL occur at the first rising edge after rst deasserts.

Verification (WIDTH=8, CW=4)
REQ-035 Scenario: ASL 0x41, c=0, count 1 -> o_data=0x82, n=1, z=0, c=0; o_busy high 1 cycle, then o_done pulses once.
REQ-036 Scenario: LSR 0x80, count 8 -> o_data=0x00, z=1, n=0, c=1; o_done one cycle after the 8th step edge.
REQ-037 Scenario: ROR 0x01, c=1, count 9 -> o_data=0x01, c=1 (full-period restore); the intermediate value after step 1 is 0x80 with c=1.
REQ-038 Scenario: ASR 0x80, count 3 -> o_data=0xF0, n=1, c=0; the same stimulus with i_rotate=1 ignores i_arith and gives RCR semantics.
REQ-039 Scenario: count 0, data 0x5A, c=1 -> o_data=0x5A, c=1, o_busy never high, o_done the cycle after the load; i_start held in DONE starts the next operation immediately.
REQ-040 Scenario: ROL 0x80, c=0, count 5; toggle i_start and i_data during SHIFT; assert rst after 2 steps -> no effect from the mid-operation inputs, all outputs at reset values, no o_done pulse; after release, a fresh ROL 0x80 count 2 gives 0x01, c=0.

Source files
------------

// File: rtl/mc6502_seq_shifter_if.sv
// Operand/result bundle for the sequential 6502-style shifter.
// The master side issues operations; the slave side (the shifter) returns
// the result register, the N/Z/C flags and the busy/done status.
interface mc6502_seq_shifter_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             i_start;
  logic [WIDTH-1:0] i_data;
  logic [CW-1:0]    i_count;
  logic             i_rotate;
  logic             i_right;
  logic             i_arith;
  logic             i_c;
  logic [WIDTH-1:0] o_data;
  logic             o_n;
  logic             o_z;
  logic             o_c;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_data, i_count, i_rotate, i_right, i_arith, i_c,
    input  o_data, o_n, o_z, o_c, o_busy, o_done
  );

  modport slave (
    input  i_start, i_data, i_count, i_rotate, i_right, i_arith, i_c,
    output o_data, o_n, o_z, o_c, o_busy, o_done
  );
endinterface

// File: rtl/mc6502_seq_shifter.sv
// Sequential shifter/rotator with 6502 semantics (ASL, LSR, ASR, ROL, ROR).
// One single-bit step is performed per clock; rotates run through the carry
// so the data path behaves as a WIDTH+1 bit ring. The operation mode is
// latched at load time and cannot change while steps remain. All outputs
// come straight from flops.
module mc6502_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mc6502_seq_shifter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             c_q,      c_d;
  logic             n_q,      n_d;
  logic             z_q,      z_d;
  logic [CW-1:0]    rem_q,    rem_d;
  logic             rotate_q, rotate_d;
  logic             right_q,  right_d;
  logic             arith_q,  arith_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH:0]   step_s;

  // One single-bit step; result is {carry_out, data_out}.
  // Arithmetic fill only applies to a plain right shift; a rotate always
  // feeds the old carry in and ignores the arith request.
  function automatic logic [WIDTH:0] step_f(
    input logic [WIDTH-1:0] d,
    input logic             c,
    input logic             rot,
    input logic             right,
    input logic             arith
  );
    logic [WIDTH:0] r;
    r = {c, d};
    if (right) begin
      if (rot) begin
        r = {d[0], c, d[WIDTH-1:1]};
      end else if (arith) begin
        r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      end else begin
        r = {d[0], 1'b0, d[WIDTH-1:1]};
      end
    end else begin
      if (rot) begin
        r = {d[WIDTH-1], d[WIDTH-2:0], c};
      end else begin
        r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  // Zero flag of a data word.
  function automatic logic zero_f(input logic [WIDTH-1:0] d);
    return (d == {WIDTH{1'b0}});
  endfunction

  // Next-state, datapath and registered-status decode.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    c_d      = c_q;
    rem_d    = rem_q;
    rotate_d = rotate_q;
    right_d  = right_q;
    arith_d  = arith_q;
    step_s   = step_f(data_q, c_q, rotate_q, right_q, arith_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          data_d   = bus.i_data;
          c_d      = bus.i_c;
          rotate_d = bus.i_rotate;
          right_d  = bus.i_right;
          arith_d  = bus.i_arith;
          rem_d    = bus.i_count;
          if (bus.i_count == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Inputs are deliberately not looked at here: the captured mode
        // and operand own the block until the last step.
        {c_d, data_d} = step_s;
        rem_d         = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d = ST_IDLE;
        rem_d   = CNT_ZERO;
      end
    endcase

    // Flags track the data register on every update.
    n_d    = data_d[WIDTH-1];
    z_d    = zero_f(data_d);
    // Status outputs are registered copies of the next state.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= {WIDTH{1'b0}};
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
      rem_q    <= CNT_ZERO;
      rotate_q <= 1'b0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      c_q      <= c_d;
      n_q      <= n_d;
      z_q      <= z_d;
      rem_q    <= rem_d;
      rotate_q <= rotate_d;
      right_q  <= right_d;
      arith_q  <= arith_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_data = data_q;
  assign bus.o_n    = n_q;
  assign bus.o_z    = z_q;
  assign bus.o_c    = c_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_mc6502_seq_shifter.sv
// Scoreboard bench for mc6502_seq_shifter (WIDTH=8, CW=4).
// Stimulus pushes hand-computed results; an independent monitor pops and
// compares on every o_done, also checking the number of busy cycles.
module tb_mc6502_seq_shifter;

  typedef struct {
    logic [7:0] data;
    logic       c;
    int         busy;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   busy_cnt;
  exp_t sb[$];

  mc6502_seq_shifter_if #(.WIDTH(8), .CW(4)) bus ();

  mc6502_seq_shifter #(.WIDTH(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completion against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 32'(bus.o_data), 32'(e.data));
          chk("sb_c",    32'(bus.o_c),    32'(e.c));
          chk("sb_n",    32'(bus.o_n),    32'(e.data[7]));
          chk("sb_z",    32'(bus.o_z),    32'(e.data == 8'h00));
          chk("sb_busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive one operation at the current negedge; i_start drops one cycle later.
  task automatic start_op(input logic [7:0] d, input logic [3:0] n, input logic rot,
                          input logic right, input logic arith, input logic c,
                          input logic [7:0] ed, input logic ec, input int eb);
    exp_t e;
    bus.i_start  = 1'b1;
    bus.i_data   = d;
    bus.i_count  = n;
    bus.i_rotate = rot;
    bus.i_right  = right;
    bus.i_arith  = arith;
    bus.i_c      = c;
    e.data = ed;
    e.c    = ec;
    e.busy = eb;
    sb.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!bus.o_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, 32'(bus.o_done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_data"}, 32'(bus.o_data), 32'h00);
    chk({name, "_c"},    32'(bus.o_c),    32'd0);
    chk({name, "_n"},    32'(bus.o_n),    32'd0);
    chk({name, "_z"},    32'(bus.o_z),    32'd1);
    chk({name, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({name, "_done"}, 32'(bus.o_done), 32'd0);
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    busy_cnt = 0;
    rst = 1'b1;
    // i_start held during reset must be ignored.
    bus.i_start  = 1'b1;
    bus.i_data   = 8'hFF;
    bus.i_count  = 4'd0;
    bus.i_rotate = 1'b0;
    bus.i_right  = 1'b0;
    bus.i_arith  = 1'b0;
    bus.i_c      = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_start_held");

    // ASL 0x41 count 1, loaded on the first edge after reset release.
    bus.i_data  = 8'h41;
    bus.i_count = 4'd1;
    bus.i_c     = 1'b0;
    e.data = 8'h82; e.c = 1'b0; e.busy = 1;
    sb.push_back(e);
    rst = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("asl_busy_after_load", 32'(bus.o_busy), 32'd1);
    chk("asl_no_early_done",   32'(bus.o_done), 32'd0);
    wait_done("asl");
    @(negedge clk);
    chk("asl_done_one_cycle", 32'(bus.o_done), 32'd0);

    // LSR 0x80 count 8.
    start_op(8'h80, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8);
    wait_done("lsr");
    @(negedge clk);

    // ROR 0x01 c=1 count 9: full period restores data and carry.
    start_op(8'h01, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 9);
    @(negedge clk);
    chk("ror_step1_data", 32'(bus.o_data), 32'h80);
    chk("ror_step1_c",    32'(bus.o_c),    32'd1);
    wait_done("ror9");

    // ASR 0x80 count 3, started back-to-back from DONE.
    start_op(8'h80, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 1'b0, 3);
    wait_done("asr");
    // Same stimulus with rotate set: arith is ignored, plain ROR.
    start_op(8'h80, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 3);
    wait_done("rcr");
    @(negedge clk);

    // Count 0 returns the operand, then i_start in DONE starts ASL 0x01.
    start_op(8'h5A, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 0);
    chk("cnt0_no_busy", 32'(bus.o_busy), 32'd0);
    wait_done("cnt0");
    start_op(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1);
    chk("b2b_busy_no_gap", 32'(bus.o_busy), 32'd1);
    wait_done("b2b");
    repeat (2) @(negedge clk);
    chk("hold_data", 32'(bus.o_data), 32'h02);
    chk("hold_done_low", 32'(bus.o_done), 32'd0);

    // ROL 0x80 count 5 with noisy inputs mid-operation, reset after 2 steps.
    bus.i_start  = 1'b1;
    bus.i_data   = 8'h80;
    bus.i_count  = 4'd5;
    bus.i_rotate = 1'b1;
    bus.i_right  = 1'b0;
    bus.i_arith  = 1'b0;
    bus.i_c      = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_data  = 8'hFF;
    bus.i_count = 4'd0;
    bus.i_right = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_c     = 1'b1;
    @(negedge clk);
    chk("rol_mid_data", 32'(bus.o_data), 32'h01);
    chk("rol_mid_c",    32'(bus.o_c),    32'd0);
    chk("rol_mid_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midshift_reset");
    @(negedge clk);
    chk_reset_vals("midshift_reset_held");
    bus.i_start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_busy", 32'(bus.o_busy), 32'd0);

    // Fresh ROL 0x80 count 2.
    start_op(8'h80, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 2);
    wait_done("rol2");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
